// File: rtl/mul_reconstruct_if.sv
// rtl/mul_reconstruct_if.sv - start/busy/done handshake and operand/result bundle for mul_reconstruct (optional ovf with RECON_OVF_EN)
interface mul_reconstruct_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     rem;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
`ifdef RECON_OVF_EN
  logic                 ovf;

  modport master (output start, quo, divisor, rem, input busy, done, product, ovf);
  modport slave  (input start, quo, divisor, rem, output busy, done, product, ovf);
`else
  modport master (output start, quo, divisor, rem, input busy, done, product);
  modport slave  (input start, quo, divisor, rem, output busy, done, product);
`endif
endinterface

// File: rtl/mul_reconstruct.sv
// rtl/mul_reconstruct.sv - sequential shift-add quo*divisor+rem, one multiplier bit per clock (RECON_OVF_EN adds ovf)
module mul_reconstruct #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  mul_reconstruct_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   sum;
`ifdef RECON_OVF_EN
  logic                 ovf_q, ovf_d;
`endif

  // Next-state: latch operands in IDLE, one add/shift step per RUN cycle, single-cycle DONE
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    product_d = product_q;
`ifdef RECON_OVF_EN
    ovf_d     = ovf_q;
`endif
    // The full 2*WIDTH accumulator cannot wrap: max result is 2^(2W) - 2^W.
    sum = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = {{WIDTH{1'b0}}, bus.rem};
          mcand_d = {{WIDTH{1'b0}}, bus.divisor};
          mplr_d  = bus.quo;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q - CW'(1);
        // Always WIDTH iterations, even once mplr has run out of ones.
        if (cnt_q == CW'(1)) begin
          product_d = sum;
`ifdef RECON_OVF_EN
          ovf_d     = |sum[2*WIDTH-1:WIDTH];
`endif
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any operation without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef RECON_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
`ifdef RECON_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
`ifdef RECON_OVF_EN
  assign bus.ovf     = ovf_q;
`endif
endmodule
